// File: rtl/nios2_dbg_vjtag_pkg.sv
// Shared types and defaults for the Nios II debug virtual-JTAG host sequencer.
package nios2_dbg_vjtag_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UIR  = 3'd1,
        S_CDR  = 3'd2,
        S_SDR  = 3'd3,
        S_UDR  = 3'd4,
        S_RTI  = 3'd5,
        S_RESP = 3'd6
    } vjtag_state_t;

    localparam int unsigned DEF_DR_WIDTH = 38;
    localparam int unsigned DEF_IR_WIDTH = 2;

    // States in which TCK runs and exactly one virtual-state strobe is asserted
    function automatic logic state_is_active(input vjtag_state_t s);
        logic active;
        case (s)
            S_UIR, S_CDR, S_SDR, S_UDR, S_RTI: active = 1'b1;
            default:                           active = 1'b0;
        endcase
        return active;
    endfunction

endpackage

// File: rtl/vjtag_tck_gen.sv
// TCK generator: low TCK_HALF clks then high TCK_HALF clks while enabled, parked low otherwise.
module vjtag_tck_gen #(
    parameter int TCK_HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int CW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(TCK_HALF - 1);

    logic [CW-1:0] cnt_r;
    logic          tck_r;

    // rise/fall flag the clk whose edge flips the tck register
    assign rise = en && (cnt_r == LAST) && !tck_r;
    assign fall = en && (cnt_r == LAST) && tck_r;
    assign tck  = tck_r;

    // Half-period counter and tck register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
            tck_r <= 1'b0;
        end else if (!en) begin
            cnt_r <= {CW{1'b0}};
            tck_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r <= {CW{1'b0}};
            tck_r <= ~tck_r;
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            tck_r <= tck_r;
        end
    end

endmodule

// File: rtl/nios2_debug_vjtag_host_seq.sv
// Host-side virtual-JTAG initiator: walks UIR/CDR/SDR/UDR/RTI for one command and returns the TDO word.
module nios2_debug_vjtag_host_seq
    import nios2_dbg_vjtag_pkg::*;
#(
    parameter int DR_WIDTH     = DEF_DR_WIDTH,
    parameter int IR_WIDTH     = DEF_IR_WIDTH,
    parameter int TCK_HALF     = 2,
    parameter int RTI_CYCLES   = 1,
    parameter int SKIP_SAME_IR = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);

    localparam int BCW = $clog2(DR_WIDTH + 1);
    localparam int RCW = $clog2(RTI_CYCLES + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DR_WIDTH);
    localparam logic [RCW-1:0] RTI_LAST = RCW'(RTI_CYCLES - 1);

    vjtag_state_t        state_r, state_next_s;
    logic [DR_WIDTH-1:0] h_r, h_next_s;
    logic [BCW-1:0]      bit_cnt_r, bit_cnt_next_s;
    logic [RCW-1:0]      rti_cnt_r, rti_cnt_next_s;
    logic [IR_WIDTH-1:0] ir_in_r;
    logic                ir_valid_r;
    logic                load_ir_s;
    logic                tck_en_s, rise_s, fall_s;
    logic                cmd_ready_r, rsp_valid_r, tdi_r;
    logic [DR_WIDTH-1:0] rsp_data_r;
    logic [IR_WIDTH-1:0] rsp_ir_out_r;
    logic                vs_uir_r, vs_cdr_r, vs_sdr_r, vs_udr_r, rti_r;

    assign tck_en_s = state_is_active(state_r);

    vjtag_tck_gen #(
        .TCK_HALF (TCK_HALF)
    ) u_tck_gen (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (tck_en_s),
        .tck   (tck),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // Next-state, shift-register and counter logic; states change only on a TCK fall
    always_comb begin
        state_next_s   = state_r;
        h_next_s       = h_r;
        bit_cnt_next_s = bit_cnt_r;
        rti_cnt_next_s = rti_cnt_r;
        load_ir_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    h_next_s       = cmd_data;
                    bit_cnt_next_s = {BCW{1'b0}};
                    if ((SKIP_SAME_IR != 0) && ir_valid_r && (cmd_ir == ir_in_r)) begin
                        state_next_s = S_CDR;
                    end else begin
                        state_next_s = S_UIR;
                        load_ir_s    = 1'b1;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_UIR: begin
                if (fall_s) state_next_s = S_CDR;
                else        state_next_s = S_UIR;
            end
            S_CDR: begin
                if (fall_s) begin
                    state_next_s   = S_SDR;
                    bit_cnt_next_s = {BCW{1'b0}};
                end else begin
                    state_next_s   = S_CDR;
                end
            end
            S_SDR: begin
                if (rise_s) begin
                    h_next_s       = {tdo, h_r[DR_WIDTH-1:1]};
                    bit_cnt_next_s = bit_cnt_r + {{(BCW-1){1'b0}}, 1'b1};
                end else begin
                    h_next_s       = h_r;
                end
                if (fall_s && (bit_cnt_r == BIT_LAST)) state_next_s = S_UDR;
                else                                   state_next_s = S_SDR;
            end
            S_UDR: begin
                if (fall_s) begin
                    state_next_s   = S_RTI;
                    rti_cnt_next_s = {RCW{1'b0}};
                end else begin
                    state_next_s   = S_UDR;
                end
            end
            S_RTI: begin
                if (fall_s && (rti_cnt_r == RTI_LAST)) begin
                    state_next_s   = S_RESP;
                end else if (fall_s) begin
                    rti_cnt_next_s = rti_cnt_r + {{(RCW-1){1'b0}}, 1'b1};
                end else begin
                    state_next_s   = S_RTI;
                end
            end
            S_RESP: begin
                if (rsp_valid_r && rsp_ready) state_next_s = S_IDLE;
                else                          state_next_s = S_RESP;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Sequencer state, shift register, IR cache and response registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            h_r          <= {DR_WIDTH{1'b0}};
            bit_cnt_r    <= {BCW{1'b0}};
            rti_cnt_r    <= {RCW{1'b0}};
            ir_in_r      <= {IR_WIDTH{1'b0}};
            ir_valid_r   <= 1'b0;
            rsp_ir_out_r <= {IR_WIDTH{1'b0}};
            rsp_data_r   <= {DR_WIDTH{1'b0}};
            rsp_valid_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            h_r       <= h_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            rti_cnt_r <= rti_cnt_next_s;
            if (load_ir_s) begin
                ir_in_r    <= cmd_ir;
                ir_valid_r <= 1'b1;
            end
            if ((state_r == S_CDR) && rise_s) begin
                rsp_ir_out_r <= ir_out;
            end
            if ((state_r == S_RESP) && !rsp_valid_r) begin
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= h_r;
            end else if (rsp_valid_r && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    // Output strobes registered from the next state so they align with state_r
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready_r <= 1'b0;
            vs_uir_r    <= 1'b0;
            vs_cdr_r    <= 1'b0;
            vs_sdr_r    <= 1'b0;
            vs_udr_r    <= 1'b0;
            rti_r       <= 1'b0;
            tdi_r       <= 1'b0;
        end else begin
            cmd_ready_r <= (state_next_s == S_IDLE);
            vs_uir_r    <= (state_next_s == S_UIR);
            vs_cdr_r    <= (state_next_s == S_CDR);
            vs_sdr_r    <= (state_next_s == S_SDR);
            vs_udr_r    <= (state_next_s == S_UDR);
            rti_r       <= (state_next_s == S_RTI);
            tdi_r       <= (state_next_s == S_SDR) ? h_next_s[0] : 1'b0;
        end
    end

    assign cmd_ready      = cmd_ready_r;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_data       = rsp_data_r;
    assign rsp_ir_out     = rsp_ir_out_r;
    assign tdi            = tdi_r;
    assign ir_in          = ir_in_r;
    assign vs_uir         = vs_uir_r;
    assign vs_cdr         = vs_cdr_r;
    assign vs_sdr         = vs_sdr_r;
    assign vs_udr         = vs_udr_r;
    assign jtag_state_rti = rti_r;

endmodule

// File: tb/tb_nios2_debug_vjtag_host_seq.sv
// Directed scoreboard bench: default-parameter DUT against a loopback target, plus a small-parameter DUT for timing.
module tb_nios2_debug_vjtag_host_seq;

    typedef struct {
        logic [37:0] data;
        logic [1:0]  ir_out;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [1:0]  cmd_ir = 2'b00, ir_out = 2'b00;
    logic [37:0] cmd_data = 38'h0;
    logic        cmd_ready, rsp_valid, tck, tdi, tdo;
    logic        vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;
    logic [37:0] rsp_data;
    logic [1:0]  rsp_ir_out, ir_in;

    logic        cmd2_valid = 1'b0, rsp2_ready = 1'b0;
    logic [1:0]  cmd2_ir = 2'b00, ir_out2 = 2'b01;
    logic [3:0]  cmd2_data = 4'h0;
    logic        cmd2_ready, rsp2_valid, tck2, tdi2;
    logic        vs_uir2, vs_cdr2, vs_sdr2, vs_udr2, rti2;
    logic [3:0]  rsp2_data;
    logic [1:0]  rsp2_ir_out, ir_in2;

    // Loopback target: 38-bit shift register clocked by tck during SDR
    logic [37:0] tgt_sr;
    logic [37:0] tgt_load_val = 38'h0;
    logic        tgt_load = 1'b0, tdi_q = 1'b0, tdo_force = 1'b0;
    assign tdo = tdo_force ? 1'b1 : tgt_sr[0];

    always @(negedge clk) tdi_q <= tdi;
    always @(posedge tck or posedge tgt_load) begin
        if (tgt_load) tgt_sr <= tgt_load_val;
        else if (vs_sdr) tgt_sr <= {tdi_q, tgt_sr[37:1]};
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Cumulative strobe-cycle and edge monitors
    int uir_tot = 0, sdr_rise_tot = 0;
    int uir2_tot = 0, cdr2_tot = 0, sdr2_tot = 0, udr2_tot = 0, rti2_tot = 0, tck2_hi_tot = 0;
    logic tck_prev = 1'b0;
    always @(negedge clk) begin
        tck_prev <= tck;
        if (vs_uir) uir_tot <= uir_tot + 1;
        if (tck && !tck_prev && vs_sdr) sdr_rise_tot <= sdr_rise_tot + 1;
        if (vs_uir2) uir2_tot <= uir2_tot + 1;
        if (vs_cdr2) cdr2_tot <= cdr2_tot + 1;
        if (vs_sdr2) sdr2_tot <= sdr2_tot + 1;
        if (vs_udr2) udr2_tot <= udr2_tot + 1;
        if (rti2) rti2_tot <= rti2_tot + 1;
        if (tck2) tck2_hi_tot <= tck2_hi_tot + 1;
    end

    nios2_debug_vjtag_host_seq dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out), .tck(tck), .tdi(tdi), .tdo(tdo),
        .ir_in(ir_in), .ir_out(ir_out), .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
        .vs_udr(vs_udr), .jtag_state_rti(jtag_state_rti)
    );

    nios2_debug_vjtag_host_seq #(
        .DR_WIDTH(4), .IR_WIDTH(2), .TCK_HALF(1), .RTI_CYCLES(3), .SKIP_SAME_IR(1)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd2_valid), .cmd_ready(cmd2_ready),
        .cmd_ir(cmd2_ir), .cmd_data(cmd2_data), .rsp_valid(rsp2_valid), .rsp_ready(rsp2_ready),
        .rsp_data(rsp2_data), .rsp_ir_out(rsp2_ir_out), .tck(tck2), .tdi(tdi2), .tdo(1'b0),
        .ir_in(ir_in2), .ir_out(ir_out2), .vs_uir(vs_uir2), .vs_cdr(vs_cdr2), .vs_sdr(vs_sdr2),
        .vs_udr(vs_udr2), .jtag_state_rti(rti2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preset_target(input logic [37:0] v);
        tgt_load_val = v;
        tgt_load = 1'b1;
        #1 tgt_load = 1'b0;
    endtask

    task automatic send(input logic [1:0] ir, input logic [37:0] d,
                        input logic [37:0] exp_d, input logic [1:0] exp_ir, input int exp_lat);
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_data  = d;
        @(posedge clk);
        #1;
        e.data = exp_d; e.ir_out = exp_ir; e.lat = exp_lat; e.t0 = cyc;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        exp_t e;
        int n = 0;
        while (!rsp_valid && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_rsp_timeout"}, {63'h0, rsp_valid}, 64'h1);
        e = sb.pop_front();
        check({tag, "_data"}, {26'h0, rsp_data}, {26'h0, e.data});
        check({tag, "_ir_out"}, {62'h0, rsp_ir_out}, {62'h0, e.ir_out});
        check({tag, "_latency"}, 64'(cyc - e.t0), 64'(e.lat));
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_ack_cmd_ready"}, {63'h0, cmd_ready}, 64'h1);
        check({tag, "_ack_rsp_valid"}, {63'h0, rsp_valid}, 64'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ub, sb0, n;
        int u2, c2, s2, d2, r2, k2, t0;
        ir_out = 2'b11;
        preset_target(38'h15_0F0F_1234);
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", {63'h0, cmd_ready}, 64'h0);
        check("reset_strobes", {58'h0, tck, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti}, 64'h0);
        check("reset_rsp", {62'h0, rsp_valid, tdi}, 64'h0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_cmd_ready", {63'h0, cmd_ready}, 64'h1);

        // Command 1: new IR -> UIR issued, loopback returns preset word
        ub = uir_tot; sb0 = sdr_rise_tot;
        send(2'b01, 38'h2A_5555_AAAA, 38'h15_0F0F_1234, 2'b11, 169);
        wait_rsp("c1");
        check("c1_uir_cycles", 64'(uir_tot - ub), 64'd4);
        check("c1_sdr_rises", 64'(sdr_rise_tot - sb0), 64'd38);
        check("c1_ir_in", {62'h0, ir_in}, 64'h1);
        ack("c1");

        // Command 2: same IR -> UIR skipped; target now holds command-1 data
        ub = uir_tot;
        send(2'b01, 38'h01_2345_6789, 38'h2A_5555_AAAA, 2'b11, 165);
        wait_rsp("c2");
        check("c2_uir_cycles", 64'(uir_tot - ub), 64'd0);
        check("c2_ir_in", {62'h0, ir_in}, 64'h1);
        ack("c2");

        // Command 3: tdo tied high, ir_out = 2'b10
        tdo_force = 1'b1; ir_out = 2'b10;
        send(2'b10, 38'h00_0000_0F0F, 38'h3F_FFFF_FFFF, 2'b10, 169);
        wait_rsp("c3");
        ack("c3");
        tdo_force = 1'b0;

        // Command 4: response back-pressure, busy-time cmd_valid ignored
        preset_target(38'h0A_BCDE_F012);
        send(2'b10, 38'h33_3333_3333, 38'h0A_BCDE_F012, 2'b10, 165);
        wait_rsp("c4");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_ir = 2'b00; cmd_data = 38'h11_1111_1111;
            @(posedge clk);
            #1;
            check("bp_rsp_valid", {63'h0, rsp_valid}, 64'h1);
            check("bp_rsp_data", {26'h0, rsp_data}, {26'h0, 38'h0A_BCDE_F012});
            check("bp_cmd_ready", {63'h0, cmd_ready}, 64'h0);
        end
        @(negedge clk) cmd_valid = 1'b0;
        ack("c4");
        repeat (10) @(posedge clk);
        #1;
        check("bp_no_accept", {59'h0, vs_uir, vs_cdr, vs_sdr, rsp_valid, cmd_ready}, 64'h1);
        check("bp_ir_in", {62'h0, ir_in}, 64'h2);

        // Command 5: reset asserted at SDR bit 17
        sb0 = sdr_rise_tot;
        send(2'b10, 38'h12_3456_789A, 38'h0, 2'b10, 0);
        n = 0;
        while ((sdr_rise_tot - sb0) < 17 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort_reached_bit17", 64'(sdr_rise_tot - sb0), 64'd17);
        reset_n = 1'b0;
        #1;
        check("abort_strobes", {58'h0, tck, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti}, 64'h0);
        check("abort_outputs", {59'h0, cmd_ready, rsp_valid, tdi, ir_in}, 64'h0);
        void'(sb.pop_back());
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_recover_ready", {63'h0, cmd_ready}, 64'h1);
        check("abort_no_rsp", {63'h0, rsp_valid}, 64'h0);

        // Command 6: same IR as before reset must reload IR
        preset_target(38'h2F_0000_00F1);
        ub = uir_tot;
        send(2'b10, 38'h05_5AA5_5AA5, 38'h2F_0000_00F1, 2'b10, 169);
        wait_rsp("c6");
        check("c6_uir_cycles", 64'(uir_tot - ub), 64'd4);
        check("c6_ir_in", {62'h0, ir_in}, 64'h2);
        ack("c6");

        // Small-parameter instance: latency 21 and exact strobe widths
        u2 = uir2_tot; c2 = cdr2_tot; s2 = sdr2_tot; d2 = udr2_tot; r2 = rti2_tot; k2 = tck2_hi_tot;
        @(negedge clk);
        cmd2_valid = 1'b1; cmd2_ir = 2'b11; cmd2_data = 4'hA;
        @(posedge clk);
        #1;
        t0 = cyc;
        @(negedge clk) cmd2_valid = 1'b0;
        n = 0;
        while (!rsp2_valid && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("d2_rsp_timeout", {63'h0, rsp2_valid}, 64'h1);
        check("d2_latency", 64'(cyc - t0), 64'd21);
        check("d2_rsp_data", {60'h0, rsp2_data}, 64'h0);
        check("d2_rsp_ir_out", {62'h0, rsp2_ir_out}, 64'h1);
        check("d2_ir_in", {62'h0, ir_in2}, 64'h3);
        check("d2_uir_width", 64'(uir2_tot - u2), 64'd2);
        check("d2_cdr_width", 64'(cdr2_tot - c2), 64'd2);
        check("d2_sdr_width", 64'(sdr2_tot - s2), 64'd8);
        check("d2_udr_width", 64'(udr2_tot - d2), 64'd2);
        check("d2_rti_width", 64'(rti2_tot - r2), 64'd6);
        check("d2_tck_high", 64'(tck2_hi_tot - k2), 64'd10);
        @(negedge clk) rsp2_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp2_ready = 1'b0;
        check("d2_ack", {61'h0, cmd2_ready, rsp2_valid, tdi2}, 64'h4);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
